// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-addressed data memory: byte/halfword
// extraction with sign/zero extension, read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned WORD_ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_readwrite,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TAG_W       = 5;
    localparam int unsigned BYTE_ADDR_W = WORD_ADDR_W + 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                wr_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [1:0]          off_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [TAG_W-1:0]    resp_rd_q;
    logic                resp_fault_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                accept;
    logic                req_fault;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   load_val;
    logic [DATA_W-1:0]   merged;

    assign accept = req_valid && req_ready;

    // Request legality: size, alignment and range of the byte address.
    always_comb begin
        req_fault = (req_addr >> BYTE_ADDR_W) != 32'd0;
        case (req_size)
            SZ_B:    ;
            SZ_H:    if (req_addr[0]) req_fault = 1'b1;
            SZ_W:    if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
            default: req_fault = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault)                         state_d = S_RESP;
                    else if (req_write && req_size == SZ_W) state_d = S_WR;
                    else                                   state_d = S_RD;
                end
            end
            S_RD:    state_d = wr_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and memory strobes, all forced low while reset is held.
    always_comb begin
        req_ready     = 1'b0;
        mem_enable    = 1'b0;
        mem_readwrite = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:  req_ready = 1'b1;
                S_RD:    mem_enable = 1'b1;
                S_WR: begin
                    mem_enable    = 1'b1;
                    mem_readwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Little-endian lane extraction with optional sign extension.
    always_comb begin
        ld_byte  = 8'(mem_rdata >> {off_q, 3'b000});
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val = mem_rdata;
        case (size_q)
            SZ_B:    load_val = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            SZ_H:    load_val = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Store data still sits right-aligned in mem_wdata_q until the read completes.
    always_comb begin
        merged = mem_rdata;
        case (size_q)
            SZ_B: begin
                case (off_q)
                    2'd0:    merged[7:0]   = mem_wdata_q[7:0];
                    2'd1:    merged[15:8]  = mem_wdata_q[7:0];
                    2'd2:    merged[23:16] = mem_wdata_q[7:0];
                    default: merged[31:24] = mem_wdata_q[7:0];
                endcase
            end
            SZ_H: begin
                if (off_q[1]) merged[31:16] = mem_wdata_q[15:0];
                else          merged[15:0]  = mem_wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // Request capture, read sampling and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            off_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_fault_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            resp_valid_q <= (state_d == S_RESP);
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        wr_q         <= req_write;
                        size_q       <= req_size;
                        signed_q     <= req_signed;
                        off_q        <= req_addr[1:0];
                        resp_rd_q    <= req_rd;
                        resp_fault_q <= req_fault;
                        resp_data_q  <= '0;
                        mem_addr_q   <= 32'(req_addr[BYTE_ADDR_W-1:2]);
                        mem_wdata_q  <= req_wdata;
                    end
                end
                S_RD: begin
                    if (wr_q) mem_wdata_q <= merged;
                    else      resp_data_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_fault = resp_fault_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
